sync_fifo_reader: RTL and testbench

Read-side controller for the team's linear synchronous FIFO. It pops words through the FIFO read port, where data is registered and presented one cycle after the `rd_en` request. It re-times those words into a valid/ready stream using a 2-entry elastic buffer. The block never reads an empty FIFO, keeps word order, and sustains one word per cycle under continuous downstream ready.

---
 rtl/sync_fifo_pkg.sv | 7 +
 rtl/sync_fifo_reader_if.sv | 11 +
 rtl/fifo_rd_skid_buf.sv | 32 +++
 rtl/sync_fifo_reader.sv | 41 ++++
 tb/tb_sync_fifo_reader.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared widths and buffer depth for the FIFO read-side blocks
package sync_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int RD_BUF_DEPTH = 2;
  typedef logic [$clog2(RD_BUF_DEPTH+1)-1:0] buf_cnt_t;
endpackage

// File: rtl/sync_fifo_reader_if.sv
// sync_fifo_reader_if: FIFO read port plus valid/ready output stream
interface sync_fifo_reader_if import sync_fifo_pkg::*; #(parameter int DATA_WIDTH = DATA_WIDTH_DEF);
  logic fifo_empty;
  logic fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic m_valid;
  logic m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  modport master(input fifo_empty, fifo_data, m_ready, output fifo_rd_en, m_valid, m_data);
  modport slave(output fifo_empty, fifo_data, m_ready, input fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: 2-entry in-order buffer, head in mem[0], push lands at the post-pop tail
module fifo_rd_skid_buf import sync_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic valid,
  output buf_cnt_t count
);
  localparam buf_cnt_t FULL = buf_cnt_t'(RD_BUF_DEPTH);
  logic [DATA_WIDTH-1:0] mem [RD_BUF_DEPTH];
  buf_cnt_t tail;
  assign tail = count - buf_cnt_t'(pop);
  assign valid = count != '0;
  assign dout = mem[0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      count <= count + buf_cnt_t'(push) - buf_cnt_t'(pop);
      if (push && tail == '0) mem[0] <= din;
      else if (pop && count == FULL) mem[0] <= mem[1];
      if (push && tail != '0) mem[1] <= din;
    end
  end
endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader: credit-based FIFO popper feeding a valid/ready stream through a 2-entry buffer
module sync_fifo_reader import sync_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  sync_fifo_reader_if.master s,
  output logic [CNT_WIDTH-1:0] pop_count,
  output logic busy
);
  buf_cnt_t buf_count;
  logic inflight_q;
  logic pop;
  logic [2:0] occ;
  assign pop = s.m_valid && s.m_ready;
  // occupancy after this edge if no new read: the pop frees a slot for a same-cycle request
  assign occ = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
  assign s.fifo_rd_en = reset && enable && !s.fifo_empty && occ < 3'(RD_BUF_DEPTH);
  assign busy = inflight_q || buf_count != '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      pop_count <= '0;
    end else begin
      inflight_q <= s.fifo_rd_en;
      pop_count <= pop_count + CNT_WIDTH'(s.fifo_rd_en);
    end
  end
  fifo_rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .push(inflight_q),
    .pop(pop),
    .din(s.fifo_data),
    .dout(s.m_data),
    .valid(s.m_valid),
    .count(buf_count)
  );
endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb_sync_fifo_reader: FIFO model plus scoreboard of popped words against the output stream
module tb_sync_fifo_reader;
  logic clk, reset, enable, en2, busy, busy2;
  logic [7:0] pop_count;
  logic [2:0] pop_count2;
  sync_fifo_reader_if #(.DATA_WIDTH(4)) b();
  sync_fifo_reader_if #(.DATA_WIDTH(4)) w();
  sync_fifo_reader #(.DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .s(b.master), .pop_count(pop_count), .busy(busy));
  sync_fifo_reader #(.DATA_WIDTH(4), .CNT_WIDTH(3)) dut_w (
    .clk(clk), .reset(reset), .enable(en2), .s(w.master), .pop_count(pop_count2), .busy(busy2));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  int errs = 0, checks = 0, reads = 0, delivered = 0;
  logic [3:0] fifo_q[$];
  logic [3:0] exp_q[$];
  logic last_rd, last_v, prev_v, prev_rdy;
  logic [3:0] last_d, prev_d;
  task automatic load(input int n);
    for (int i = 1; i <= n; i++) fifo_q.push_back(4'(i));
    b.fifo_empty = 0;
  endtask
  task automatic tick();
    logic [3:0] e;
    #1;
    checks++;
    if (b.fifo_rd_en && b.fifo_empty) begin errs++; $display("FAIL rd_on_empty rd_en=%b empty=%b", b.fifo_rd_en, b.fifo_empty); end
    if (prev_v && !prev_rdy) begin
      checks++;
      if (b.m_valid !== 1'b1 || b.m_data !== prev_d) begin
        errs++; $display("FAIL hold valid=%b data=%0d want valid=1 data=%0d", b.m_valid, b.m_data, prev_d);
      end
    end
    if (b.m_valid && b.m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin errs++; $display("FAIL extra_word data=%0d want none", b.m_data); end
      else begin
        e = exp_q.pop_front();
        if (b.m_data !== e) begin errs++; $display("FAIL order data=%0d want %0d", b.m_data, e); end
      end
      delivered++;
    end
    last_rd = b.fifo_rd_en; last_v = b.m_valid; last_d = b.m_data;
    prev_v = b.m_valid; prev_rdy = b.m_ready; prev_d = b.m_data;
    if (last_rd) reads++;
    @(posedge clk); #1;
    if (last_rd) begin
      e = fifo_q.pop_front();
      b.fifo_data = e;
      exp_q.push_back(e);
      b.fifo_empty = fifo_q.size() == 0;
    end
    @(negedge clk);
  endtask
  task automatic drain(output bit ok);
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      if (fifo_q.size() == 0 && !busy && !b.fifo_rd_en) ok = 1;
      else tick();
    end
    checks++;
    if (!ok) begin errs++; $display("FAIL drain_timeout fifo_left=%0d busy=%b want 0 0", fifo_q.size(), busy); end
    checks++;
    if (exp_q.size() != 0) begin errs++; $display("FAIL undelivered left=%0d want 0", exp_q.size()); end
  endtask
  task automatic test_reset();
    reset = 0; enable = 1; fifo_q.push_back(4'd5); b.fifo_empty = 0;
    #1;
    checks += 5;
    if (b.fifo_rd_en !== 1'b0) begin errs++; $display("FAIL rst_rd_en got=%b want 0", b.fifo_rd_en); end
    if (b.m_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b want 0", b.m_valid); end
    if (b.m_data !== 4'd0) begin errs++; $display("FAIL rst_data got=%0d want 0", b.m_data); end
    if (pop_count !== 8'd0) begin errs++; $display("FAIL rst_pop_count got=%0d want 0", pop_count); end
    if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b want 0", busy); end
    fifo_q.delete(); b.fifo_empty = 1;
    @(negedge clk); reset = 1;
  endtask
  task automatic test_empty();
    int bad = 0;
    enable = 1; b.m_ready = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_rd !== 1'b0 || last_v !== 1'b0) bad++;
    end
    checks += 2;
    if (bad != 0) begin errs++; $display("FAIL empty_idle bad_cycles=%0d want 0", bad); end
    if (pop_count !== 8'd0) begin errs++; $display("FAIL empty_pop_count got=%0d want 0", pop_count); end
  endtask
  task automatic test_stream();
    load(8); enable = 1; b.m_ready = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks += 2;
      if (last_rd !== (i < 8)) begin errs++; $display("FAIL stream_rd cyc=%0d got=%b want %b", i, last_rd, i < 8); end
      if (last_v !== (i >= 2 && i < 10)) begin errs++; $display("FAIL stream_valid cyc=%0d got=%b want %b", i, last_v, i >= 2 && i < 10); end
      if (i >= 2 && i < 10) begin
        checks++;
        if (last_d !== 4'(i - 1)) begin errs++; $display("FAIL stream_latency cyc=%0d got=%0d want %0d", i, last_d, i - 1); end
      end
    end
    checks += 2;
    if (pop_count !== 8'd8) begin errs++; $display("FAIL stream_pop_count got=%0d want 8", pop_count); end
    if (busy !== 1'b0) begin errs++; $display("FAIL stream_busy got=%b want 0", busy); end
  endtask
  task automatic test_backpressure();
    int r0, d0;
    bit ok;
    load(8); b.m_ready = 0; r0 = reads;
    repeat (6) tick();
    checks += 4;
    if (reads - r0 != 2) begin errs++; $display("FAIL bp_reads got=%0d want 2", reads - r0); end
    if (last_rd !== 1'b0) begin errs++; $display("FAIL bp_rd_en got=%b want 0", last_rd); end
    if (last_v !== 1'b1) begin errs++; $display("FAIL bp_valid got=%b want 1", last_v); end
    if (last_d !== 4'd1) begin errs++; $display("FAIL bp_data got=%0d want 1", last_d); end
    b.m_ready = 1; d0 = delivered;
    repeat (8) tick();
    checks++;
    if (delivered - d0 != 8) begin errs++; $display("FAIL bp_gapless got=%0d want 8", delivered - d0); end
    drain(ok);
  endtask
  task automatic test_enable_drop();
    int r0, d0;
    bit ok;
    load(8); enable = 1; b.m_ready = 1; r0 = reads; d0 = delivered;
    for (int i = 0; i < 20 && reads - r0 < 3; i++) tick();
    enable = 0;
    repeat (8) tick();
    checks += 3;
    if (reads - r0 != 3) begin errs++; $display("FAIL en_reads got=%0d want 3", reads - r0); end
    if (delivered - d0 != 3) begin errs++; $display("FAIL en_delivered got=%0d want 3", delivered - d0); end
    if (busy !== 1'b0) begin errs++; $display("FAIL en_busy got=%b want 0", busy); end
    enable = 1;
    drain(ok);
    checks++;
    if (delivered - d0 != 8) begin errs++; $display("FAIL en_total got=%0d want 8", delivered - d0); end
  endtask
  task automatic test_reset_mid();
    int rem, d0;
    bit ok;
    load(8); enable = 1; b.m_ready = 1;
    repeat (4) tick();
    reset = 0;
    #1;
    checks += 4;
    if (b.m_valid !== 1'b0) begin errs++; $display("FAIL mid_valid got=%b want 0", b.m_valid); end
    if (b.fifo_rd_en !== 1'b0) begin errs++; $display("FAIL mid_rd_en got=%b want 0", b.fifo_rd_en); end
    if (pop_count !== 8'd0) begin errs++; $display("FAIL mid_pop_count got=%0d want 0", pop_count); end
    if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got=%b want 0", busy); end
    exp_q.delete(); prev_v = 0;
    tick();
    reset = 1;
    rem = fifo_q.size(); d0 = delivered;
    drain(ok);
    checks += 2;
    if (delivered - d0 != rem) begin errs++; $display("FAIL mid_delivered got=%0d want %0d", delivered - d0, rem); end
    if (pop_count !== 8'(rem)) begin errs++; $display("FAIL mid_restart_count got=%0d want %0d", pop_count, rem); end
  endtask
  task automatic test_wrap();
    en2 = 1; w.m_ready = 1; w.fifo_empty = 0;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (w.fifo_rd_en !== 1'b1) begin errs++; $display("FAIL wrap_rd cyc=%0d got=%b want 1", i, w.fifo_rd_en); end
      @(posedge clk); #1;
      checks++;
      if (pop_count2 !== 3'((i + 1) % 8)) begin errs++; $display("FAIL wrap_count cyc=%0d got=%0d want %0d", i, pop_count2, (i + 1) % 8); end
      @(negedge clk);
    end
    w.fifo_empty = 1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    reset = 0; enable = 0; en2 = 1;
    b.fifo_empty = 1; b.fifo_data = '0; b.m_ready = 1;
    w.fifo_empty = 1; w.fifo_data = 4'd9; w.m_ready = 1;
    prev_v = 0; prev_rdy = 0; prev_d = '0;
    @(negedge clk);
    test_reset();
    test_empty();
    test_stream();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
